router_ingress: RTL and testbench

- Parametrised ingress front-end of the router: accepts a byte stream over a req/ack handshake, parses a one-byte header (address + payload size), and routes the header and payload into one of NUM_CH per-channel FIFOs.
- Optionally checks a trailing CRC-8 byte and flushes the target FIFO's packet on mismatch.
- Discards packets to unknown or disabled channels while still consuming their bytes.
- Sits between the external input port and the channel FIFO array.

---
 rtl/router_pkg.sv | 21 ++
 rtl/crc8_step.sv | 21 ++
 rtl/router_ingress.sv | 184 ++++++++++++++++++
 tb/tb_router_ingress.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router ingress front-end.
package router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  localparam int HDR_SIZE_LSB = 0;

  // Address field sits directly above the size field in the header byte.
  function automatic int hdr_addr_lsb(input int size_w);
    return size_w;
  endfunction

endpackage

// File: rtl/crc8_step.sv
// One-byte CRC-8 update (poly 0x07, MSB first), purely combinational.
// Latency 0; no flow control.
module crc8_step
  import router_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/router_ingress.sv
// Parses header byte, routes header+payload to a channel FIFO, checks optional CRC-8.
// Latency 1 cycle to FIFO write; backpressure: ack withheld while target fifo_full (IDLE/PAYLOAD only).
module router_ingress
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 2,
  parameter int SIZE_W     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_in_req,
  output logic                     data_in_ack,
  output logic [NUM_CH-1:0]        fifo_push,
  output logic [NUM_CH-1:0]        fifo_pkt_start,
  output logic [NUM_CH-1:0]        fifo_flush,
  input  logic [NUM_CH-1:0]        fifo_full,
  output logic [DATA_WIDTH-1:0]    fifo_data,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     crc_en,
  output logic                     drop_pulse,
  output logic                     crc_err_pulse
);

  localparam int CNT_W    = SIZE_W + 1;
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ADDR_LSB = hdr_addr_lsb(SIZE_W);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SEL_W-1:0]  sel, sel_nxt;
  logic [7:0]        crc_acc, crc_nxt;
  logic              crc_en_q, crc_en_nxt;

  logic              ack_nxt;
  logic [NUM_CH-1:0] push_nxt, start_nxt, flush_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic              drop_nxt, err_nxt;

  logic [SIZE_W-1:0] hdr_size;
  logic [ADDR_W-1:0] hdr_addr;
  logic              hit;
  logic [SEL_W-1:0]  hit_sel;
  logic [CNT_W-1:0]  disc_cnt;
  logic              xfer;
  logic [7:0]        crc_seed, crc_step_out;

  assign hdr_size = data_in[HDR_SIZE_LSB +: SIZE_W];
  assign hdr_addr = data_in[ADDR_LSB +: ADDR_W];
  assign xfer     = data_in_req && data_in_ack;
  assign disc_cnt = {1'b0, hdr_size} + CNT_W'(crc_en);

  // Header byte is hashed from the init value; later bytes chain on the accumulator.
  assign crc_seed = (state == ST_IDLE) ? CRC8_INIT : crc_acc;

  crc8_step u_crc8_step (
    .crc_in  (crc_seed),
    .byte_in (data_in[7:0]),
    .crc_out (crc_step_out)
  );

  // Lowest enabled channel with a matching address wins.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en[i] && (ch_addr[i*ADDR_W +: ADDR_W] == hdr_addr)) begin
        hit     = 1'b1;
        hit_sel = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sel_nxt    = sel;
    crc_nxt    = crc_acc;
    crc_en_nxt = crc_en_q;
    ack_nxt    = 1'b0;
    push_nxt   = '0;
    start_nxt  = '0;
    flush_nxt  = '0;
    data_nxt   = fifo_data;
    drop_nxt   = 1'b0;
    err_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (data_in_req) begin
          if (hit) begin
            ack_nxt = !data_in_ack && !fifo_full[hit_sel];
            if (xfer) begin
              push_nxt[hit_sel]  = 1'b1;
              start_nxt[hit_sel] = 1'b1;
              data_nxt   = data_in;
              sel_nxt    = hit_sel;
              cnt_nxt    = CNT_W'(hdr_size);
              crc_nxt    = crc_step_out;
              crc_en_nxt = crc_en;
              if (hdr_size != '0)  state_nxt = ST_PAYLOAD;
              else if (crc_en)     state_nxt = ST_CRC;
              else                 state_nxt = ST_IDLE;
            end
          end else begin
            ack_nxt = !data_in_ack;
            if (xfer) begin
              drop_nxt   = 1'b1;
              cnt_nxt    = disc_cnt;
              crc_en_nxt = crc_en;
              state_nxt  = (disc_cnt != '0) ? ST_DISCARD : ST_IDLE;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        ack_nxt = data_in_req && !data_in_ack && !fifo_full[sel];
        if (xfer) begin
          push_nxt[sel] = 1'b1;
          data_nxt = data_in;
          crc_nxt  = crc_step_out;
          cnt_nxt  = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = crc_en_q ? ST_CRC : ST_IDLE;
        end
      end

      ST_CRC: begin
        ack_nxt = data_in_req && !data_in_ack;
        if (xfer) begin
          if (data_in[7:0] != crc_acc) begin
            flush_nxt[sel] = 1'b1;
            err_nxt        = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
      end

      ST_DISCARD: begin
        ack_nxt = data_in_req && !data_in_ack;
        if (xfer) begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      sel            <= '0;
      crc_acc        <= CRC8_INIT;
      crc_en_q       <= 1'b0;
      data_in_ack    <= 1'b0;
      fifo_push      <= '0;
      fifo_pkt_start <= '0;
      fifo_flush     <= '0;
      fifo_data      <= '0;
      drop_pulse     <= 1'b0;
      crc_err_pulse  <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      sel            <= sel_nxt;
      crc_acc        <= crc_nxt;
      crc_en_q       <= crc_en_nxt;
      data_in_ack    <= ack_nxt;
      fifo_push      <= push_nxt;
      fifo_pkt_start <= start_nxt;
      fifo_flush     <= flush_nxt;
      fifo_data      <= data_nxt;
      drop_pulse     <= drop_nxt;
      crc_err_pulse  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_router_ingress.sv
// Directed bench for router_ingress: routing, CRC check/flush, discard, backpressure, reset.
module tb_router_ingress;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_in_req;
  logic       data_in_ack;
  logic [2:0] fifo_push, fifo_pkt_start, fifo_flush, fifo_full;
  logic [7:0] fifo_data;
  logic [5:0] ch_addr;
  logic [2:0] ch_en;
  logic       crc_en;
  logic       drop_pulse, crc_err_pulse;

  router_ingress #(.DATA_WIDTH(8), .NUM_CH(3), .ADDR_W(2), .SIZE_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_req(data_in_req),
    .data_in_ack(data_in_ack), .fifo_push(fifo_push), .fifo_pkt_start(fifo_pkt_start),
    .fifo_flush(fifo_flush), .fifo_full(fifo_full), .fifo_data(fifo_data),
    .ch_addr(ch_addr), .ch_en(ch_en), .crc_en(crc_en),
    .drop_pulse(drop_pulse), .crc_err_pulse(crc_err_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int ack_cnt = 0, consec = 0, push_total = 0, drop_cnt = 0;
  logic prev_ack = 1'b0;

  logic [2:0] last_push, last_start, last_flush;
  logic [7:0] last_data;
  logic       last_drop, last_err;
  int         last_ack_cyc;

  always @(posedge clk) begin
    cyc++;
    if (data_in_ack) begin
      ack_cnt++;
      if (prev_ack) consec++;
    end
    prev_ack = data_in_ack;
    push_total += $countones(fifo_push);
    if (drop_pulse) drop_cnt++;
  end

  // Offer one byte, wait for its ack, and capture the outputs of the transfer cycle.
  task automatic send(input logic [7:0] b);
    int n;
    data_in = b;
    data_in_req = 1'b1;
    n = 0;
    while (data_in_ack !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (data_in_ack !== 1'b1) begin
      checks++;
      $display("FAIL ack_timeout byte %h: ack=%b want 1", b, data_in_ack);
      last_push = 'x; last_start = 'x; last_flush = 'x; last_data = 'x;
      last_drop = 1'bx; last_err = 1'bx;
      data_in_req = 1'b0;
    end else begin
      last_ack_cyc = cyc;
      @(negedge clk);
      last_push  = fifo_push;
      last_start = fifo_pkt_start;
      last_flush = fifo_flush;
      last_data  = fifo_data;
      last_drop  = drop_pulse;
      last_err   = crc_err_pulse;
      data_in_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({data_in_ack, fifo_push, fifo_pkt_start, fifo_flush, drop_pulse, crc_err_pulse} !== 12'b0)
      $display("FAIL reset_ctrl: got %b want 0", {data_in_ack, fifo_push, fifo_pkt_start, fifo_flush, drop_pulse, crc_err_pulse});
    else passed++;
    checks++; if (fifo_data !== 8'h00) $display("FAIL reset_data: got %h want 00", fifo_data); else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({data_in_ack, fifo_push} !== 4'b0) $display("FAIL idle_no_req: got %b want 0", {data_in_ack, fifo_push});
    else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] pl [3];
    int prev;
    pl = '{8'hAA, 8'hBB, 8'hCC};
    ch_addr = {2'd2, 2'd1, 2'd0}; ch_en = 3'b111; crc_en = 1'b0;
    send(8'h43);
    checks++; if (last_push !== 3'b010) $display("FAIL basic_hdr_push: got %b want 010", last_push); else passed++;
    checks++; if (last_start !== 3'b010) $display("FAIL basic_hdr_start: got %b want 010", last_start); else passed++;
    checks++; if (last_data !== 8'h43) $display("FAIL basic_hdr_data: got %h want 43", last_data); else passed++;
    for (int i = 0; i < 3; i++) begin
      prev = last_ack_cyc;
      send(pl[i]);
      checks++; if ({last_push, last_start, last_flush} !== 9'b010_000_000)
        $display("FAIL basic_pl%0d_ctrl: got %b want 010000000", i, {last_push, last_start, last_flush});
      else passed++;
      checks++; if (last_data !== pl[i]) $display("FAIL basic_pl%0d_data: got %h want %h", i, last_data, pl[i]); else passed++;
      checks++; if (last_ack_cyc - prev !== 2) $display("FAIL basic_ack_gap%0d: got %0d want 2", i, last_ack_cyc - prev); else passed++;
    end
  endtask

  task automatic test_crc();
    logic [7:0] pkt [3];
    pkt = '{8'h02, 8'h01, 8'h02};
    crc_en = 1'b1;
    send(pkt[0]);
    crc_en = 1'b0;
    checks++; if ({last_push, last_start} !== 6'b001_001) $display("FAIL crc_hdr: got %b want 001001", {last_push, last_start}); else passed++;
    send(pkt[1]);
    send(pkt[2]);
    checks++; if ({last_push, last_data} !== {3'b001, 8'h02}) $display("FAIL crc_pl_last: got %b/%h want 001/02", last_push, last_data); else passed++;
    send(8'hCD);
    checks++; if ({last_push, last_flush, last_err} !== 7'b0) $display("FAIL crc_good: got %b want 0", {last_push, last_flush, last_err}); else passed++;

    crc_en = 1'b1;
    for (int i = 0; i < 3; i++) send(pkt[i]);
    send(8'hCC);
    crc_en = 1'b0;
    checks++; if ({last_push, last_flush, last_err} !== 7'b000_001_1) $display("FAIL crc_bad: got %b want 0000011", {last_push, last_flush, last_err}); else passed++;
    @(negedge clk);
    checks++; if ({fifo_flush, crc_err_pulse} !== 4'b0) $display("FAIL crc_bad_pulse_len: got %b want 0", {fifo_flush, crc_err_pulse}); else passed++;
  endtask

  task automatic test_discard();
    int a0, p0, d0;
    crc_en = 1'b1; fifo_full = 3'b111;
    @(negedge clk);
    a0 = ack_cnt; p0 = push_total; d0 = drop_cnt;
    send(8'hC4);
    crc_en = 1'b0;
    checks++; if ({last_drop, last_push} !== 4'b1_000) $display("FAIL disc_hdr: got %b want 1000", {last_drop, last_push}); else passed++;
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    @(negedge clk);
    checks++; if (ack_cnt - a0 !== 6) $display("FAIL disc_acks: got %0d want 6", ack_cnt - a0); else passed++;
    checks++; if (push_total - p0 !== 0) $display("FAIL disc_pushes: got %0d want 0", push_total - p0); else passed++;
    checks++; if (drop_cnt - d0 !== 1) $display("FAIL disc_drops: got %0d want 1", drop_cnt - d0); else passed++;
    fifo_full = 3'b000;
    send(8'h40);
    checks++; if ({last_push, last_start} !== 6'b010_010) $display("FAIL disc_back_idle: got %b want 010010", {last_push, last_start}); else passed++;
  endtask

  task automatic test_enable();
    ch_addr = {2'd1, 2'd1, 2'd0}; ch_en = 3'b101;
    send(8'h40);
    checks++; if (last_push !== 3'b100) $display("FAIL en_skip_disabled: got %b want 100", last_push); else passed++;
    ch_en = 3'b111;
    send(8'h40);
    checks++; if (last_push !== 3'b010) $display("FAIL en_lowest_wins: got %b want 010", last_push); else passed++;
    ch_addr = {2'd2, 2'd1, 2'd0};
  endtask

  task automatic test_full();
    int a0, p0;
    send(8'h44);
    send(8'h11);
    send(8'h22);
    fifo_full = 3'b010;
    data_in = 8'h33; data_in_req = 1'b1;
    @(negedge clk);
    a0 = ack_cnt; p0 = push_total;
    repeat (10) @(negedge clk);
    checks++; if (ack_cnt - a0 !== 0) $display("FAIL full_stall_ack: got %0d want 0", ack_cnt - a0); else passed++;
    checks++; if (push_total - p0 !== 0) $display("FAIL full_stall_push: got %0d want 0", push_total - p0); else passed++;
    fifo_full = 3'b000;
    send(8'h33);
    checks++; if ({last_push, last_data} !== {3'b010, 8'h33}) $display("FAIL full_resume3: got %b/%h want 010/33", last_push, last_data); else passed++;
    send(8'h44);
    checks++; if ({last_push, last_start, last_data} !== {6'b010_000, 8'h44}) $display("FAIL full_resume4: got %b/%h want 010000/44", {last_push, last_start}, last_data); else passed++;
    send(8'h40);
    checks++; if ({last_push, last_start} !== 6'b010_010) $display("FAIL size0_hdr: got %b want 010010", {last_push, last_start}); else passed++;
  endtask

  task automatic test_reset_mid();
    send(8'h43);
    send(8'hAA);
    rst_n = 1'b0;
    #1;
    checks++; if ({data_in_ack, fifo_push, fifo_pkt_start, fifo_data} !== 15'b0)
      $display("FAIL rst_mid_outputs: got %b want 0", {data_in_ack, fifo_push, fifo_pkt_start, fifo_data});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h41);
    checks++; if ({last_push, last_start, last_data} !== {6'b010_010, 8'h41}) $display("FAIL rst_mid_hdr: got %b/%h want 010010/41", {last_push, last_start}, last_data); else passed++;
    send(8'h5A);
    checks++; if ({last_push, last_start, last_data} !== {6'b010_000, 8'h5A}) $display("FAIL rst_mid_pl: got %b/%h want 010000/5a", {last_push, last_start}, last_data); else passed++;
    send(8'h40);
    checks++; if (last_start !== 3'b010) $display("FAIL rst_mid_next: got %b want 010", last_start); else passed++;
  endtask

  initial begin
    rst_n = 1'b0; data_in = 8'h00; data_in_req = 1'b0; fifo_full = 3'b000;
    ch_addr = {2'd2, 2'd1, 2'd0}; ch_en = 3'b111; crc_en = 1'b0;
    test_reset();
    test_basic();
    test_crc();
    test_discard();
    test_enable();
    test_full();
    test_reset_mid();
    checks++; if (consec !== 0) $display("FAIL ack_back_to_back: got %0d want 0", consec); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
